// File: rtl/pipe_mult.sv
// pipe_mult: fully pipelined unsigned multiplier answering the start/done
// multiply handshake. One operand pair per cycle; the 2*WIDTH-bit product
// appears with a one-cycle done pulse STAGES cycles after the start cycle.
// Each stage retires WIDTH/STAGES multiplier bits into a running partial sum.
module pipe_mult #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CHUNK = (STAGES == 0) ? 1 : WIDTH / STAGES;

  if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_stages
    $error("pipe_mult: STAGES must be nonzero and divide WIDTH evenly");
  end

  // Add the low CHUNK multiplier bits times the (already shifted) multiplicand.
  function automatic logic [PW-1:0] acc(input logic [PW-1:0]    sum,
                                        input logic [PW-1:0]    cand,
                                        input logic [WIDTH-1:0] plier);
    logic [PW-1:0] digit;
    digit            = '0;
    digit[CHUNK-1:0] = plier[CHUNK-1:0];
    return sum + cand * digit;
  endfunction

  if (STAGES == 1) begin : g_single
    // Single stage: the whole product is formed at issue.
    always_ff @(posedge clock) begin
      if (reset) begin
        product <= '0;
        done    <= 1'b0;
      end else begin
        done <= start;
        if (start) product <= acc('0, PW'(mcand), mplier);
      end
    end
  end else begin : g_chain
    // Stages 0..STAGES-2 live in the arrays below; the output register pair
    // (product, done) acts as the final stage so that done rises exactly
    // STAGES cycles after start while product still holds between results.
    localparam int unsigned LAST = STAGES - 1;

    logic [PW-1:0]    sum_q   [LAST];
    logic [PW-1:0]    cand_q  [LAST];
    logic [WIDTH-1:0] plier_q [LAST];
    logic [LAST-1:0]  valid_q;

    // Shift chain: every slot advances each cycle; only valid slots update product.
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int unsigned k = 0; k < LAST; k++) begin
          sum_q[k]   <= '0;
          cand_q[k]  <= '0;
          plier_q[k] <= '0;
        end
        valid_q <= '0;
        product <= '0;
        done    <= 1'b0;
      end else begin
        valid_q[0] <= start;
        sum_q[0]   <= acc('0, PW'(mcand), mplier);
        cand_q[0]  <= PW'(mcand);
        plier_q[0] <= mplier;
        for (int unsigned k = 1; k < LAST; k++) begin
          valid_q[k] <= valid_q[k-1];
          sum_q[k]   <= acc(sum_q[k-1], cand_q[k-1] << CHUNK, plier_q[k-1] >> CHUNK);
          cand_q[k]  <= cand_q[k-1] << CHUNK;
          plier_q[k] <= plier_q[k-1] >> CHUNK;
        end
        done <= valid_q[LAST-1];
        if (valid_q[LAST-1])
          product <= acc(sum_q[LAST-1], cand_q[LAST-1] << CHUNK, plier_q[LAST-1] >> CHUNK);
      end
    end
  end

endmodule

// File: tb/tb_pipe_mult.sv
// tb_pipe_mult: self-checking bench for pipe_mult. A queue-based model
// predicts done/product per cycle from issue time + fixed latency and the
// exact 64-bit product; directed cases also check literal results.
module tb_pipe_mult;

  localparam int unsigned W = 32;
  localparam int unsigned S = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          start;
  logic [2*W-1:0] product;
  logic          done;

  pipe_mult #(.WIDTH(W), .STAGES(S)) dut (
    .clock  (clock),
    .reset  (reset),
    .mcand  (mcand),
    .mplier (mplier),
    .start  (start),
    .product(product),
    .done   (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    logic [63:0] val;
  } rec_t;

  rec_t        pend[$];   // model: outstanding operations with due edge
  rec_t        got_q[$];  // observed dones
  int unsigned cycle = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_prod = '0;
  logic        chk_en = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: an accepted start at edge N is due at edge N+S-1.
  always @(posedge clock) begin
    rec_t r;
    cycle = cycle + 1;
    if (reset) begin
      pend.delete();
      m_done = 1'b0;
      m_prod = '0;
    end else begin
      if (start) begin
        r.cyc = cycle + S - 1;
        r.val = 64'(mcand) * 64'(mplier);
        pend.push_back(r);
      end
      m_done = 1'b0;
      if (pend.size() > 0 && pend[0].cyc == cycle) begin
        m_done = 1'b1;
        m_prod = pend[0].val;
        void'(pend.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Per-cycle compare against the model, plus a log of observed results.
  always @(negedge clock) begin
    rec_t r;
    if (chk_en) begin
      check("done", 64'(done), 64'(m_done));
      check("product", product, m_prod);
      if (done === 1'b1) begin
        r.cyc = cycle;
        r.val = product;
        got_q.push_back(r);
      end
    end
  end

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    start  = s;
    mcand  = a;
    mplier = b;
    @(negedge clock);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, $urandom, $urandom);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(9))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int unsigned e0;
    int unsigned e1;
    int unsigned thr;
    reset  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);

    // Single operation, first cycle after reset.
    got_q.delete();
    e0 = cycle + 1;
    drive(1'b1, 32'h0000B504, 32'h0000B504);
    idle(12);
    check("single_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) begin
      check("single_latency", 64'(got_q[0].cyc - e0 + 1), 64'd8);
      check("single_value", got_q[0].val, 64'h000000007FFEA810);
    end

    // Extremes.
    got_q.delete();
    drive(1'b1, 32'h00000000, 32'hFFFFFFFF);
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drive(1'b1, 32'h00010000, 32'h00010000);
    idle(12);
    check("ext_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("ext_zero", got_q[0].val, 64'h0);
      check("ext_ones", got_q[1].val, 64'hFFFFFFFE00000001);
      check("ext_pow", got_q[2].val, 64'h0000000100000000);
    end

    // Back-to-back.
    got_q.delete();
    e0 = cycle + 1;
    drive(1'b1, 32'h1, 32'h1);
    drive(1'b1, 32'h2, 32'h3);
    drive(1'b1, 32'hFFFF, 32'hFFFF);
    drive(1'b1, 32'h80000000, 32'h2);
    idle(12);
    check("b2b_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      check("b2b_latency", 64'(got_q[0].cyc - e0 + 1), 64'd8);
      check("b2b_v0", got_q[0].val, 64'h1);
      check("b2b_v1", got_q[1].val, 64'h6);
      check("b2b_v2", got_q[2].val, 64'hFFFE0001);
      check("b2b_v3", got_q[3].val, 64'h100000000);
      check("b2b_contig", 64'(got_q[3].cyc - got_q[0].cyc), 64'd3);
    end

    // Gapped issue: starts in relative cycles 0, 2, 5.
    got_q.delete();
    e0 = cycle + 1;
    drive(1'b1, 32'd3, 32'd5);
    drive(1'b0, 32'd9, 32'd9);
    drive(1'b1, 32'd7, 32'd11);
    drive(1'b0, 32'd1, 32'd1);
    drive(1'b0, 32'd2, 32'd2);
    drive(1'b1, 32'd13, 32'd17);
    idle(14);
    check("gap_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("gap_t0", 64'(got_q[0].cyc - e0), 64'd7);
      check("gap_t1", 64'(got_q[1].cyc - e0), 64'd9);
      check("gap_t2", 64'(got_q[2].cyc - e0), 64'd12);
      check("gap_v2", got_q[2].val, 64'd221);
    end

    // Reset mid-flight, with start held during reset, then a fresh op.
    got_q.delete();
    drive(1'b1, 32'd100, 32'd100);
    drive(1'b1, 32'd200, 32'd200);
    drive(1'b1, 32'd300, 32'd300);
    drive(1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    drive(1'b1, 32'd55, 32'd55);
    reset = 1'b0;
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    e1 = cycle + 1;
    drive(1'b1, 32'd7, 32'd9);
    idle(12);
    check("rst_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) begin
      check("rst_latency", 64'(got_q[0].cyc - e1 + 1), 64'd8);
      check("rst_value", got_q[0].val, 64'd63);
    end

    // Random regression with varying start density.
    got_q.delete();
    thr = 50;
    for (int unsigned i = 0; i < 10000; i++) begin
      if (i % 500 == 0) thr = $urandom_range(100, 10);
      while ($urandom_range(100, 1) > thr) drive(1'b0, $urandom, $urandom);
      drive(1'b1, rnd_op(), rnd_op());
    end
    idle(12);
    check("rand_count", 64'(got_q.size()), 64'd10000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mult.md
Name: pipe_mult

Overview:
- Fully pipelined unsigned integer multiplier; the responder side of the start/done multiply handshake used by the integer-square-root block.
- Accepts one operand pair per cycle on a start pulse and returns the full-width product with a one-cycle done pulse exactly STAGES cycles later.
- Results come out in issue order.
- Sits beside the ISR controller, which issues the current guess as both operands and compares the product against the target value.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- STAGES, 8, pipeline depth. Must divide WIDTH evenly; elaboration-time error otherwise. Each stage consumes WIDTH/STAGES multiplier bits.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mcand  input  WIDTH  multiplicand, sampled when start=1
- mplier  input  WIDTH  multiplier, sampled when start=1
- start  input  1  issue request, one operation per cycle high
- product  output  2*WIDTH  mcand*mplier; valid when done=1
- done  output  1  one-cycle pulse per completed operation

Behaviour:
- Reset values: done=0, product=0, all stage valid bits=0, all stage data registers=0.
- Reset is synchronous: it takes effect at the clock edge where reset=1, not before.
- Reset mid-operation: all in-flight operations are dropped and no done is produced for them.
- start is ignored in any cycle with reset=1.
- A start in the first cycle after reset deasserts is accepted.
- Issue: at the edge where start=1, stage 0 captures mcand, mplier and valid=1. No backpressure; start may be high every cycle.
- Stage k (k=0..STAGES-1) holds:
  - partial sum (2*WIDTH bits);
  - multiplicand shifted left by k*(WIDTH/STAGES) (2*WIDTH bits);
  - remaining multiplier bits, shifted right by the same amount;
  - valid bit.
- Each stage adds (shifted mcand * low WIDTH/STAGES multiplier bits) into the partial sum. All arithmetic is unsigned, zero-extended to 2*WIDTH bits, with no truncation. The final sum equals the exact product; overflow is impossible.
- Valid bits advance one stage per cycle regardless of start. Invalid slots still shift but produce no done.
- Latency:
  - A start sampled at edge N produces done=1 and the correct product during the cycle after edge N+STAGES-1, i.e. STAGES cycles after the start cycle.
  - Throughput is one result per cycle.
- done is high for exactly one cycle per accepted start.
- Back-to-back starts produce back-to-back dones in the same order. Gaps in start reproduce the same gaps in done.
- product is registered and holds the last completed result until the next done. It is never updated by invalid slots.
- Operand changes while start=0 have no effect.
- Boundary cases:
  - A zero operand gives product 0.
  - All-ones operands give 2^(2*WIDTH) - 2^(WIDTH+1) + 1.
- Simultaneous reset and an emerging done: reset wins; done=0 and product=0 on the next cycle.
- No state machine beyond the valid shift chain. The block is a pure pipeline with no idle/busy status.

Test Plan:
- Single op: reset, then start with mcand=0xB504, mplier=0xB504 -> done=1 exactly 8 cycles later, product=0x000000007FFEA810; done low on all other cycles.
- Extremes: 0x0 * 0xFFFFFFFF -> 0x0. 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE00000001. 0x00010000 * 0x00010000 -> 0x0000000100000000.
- Back-to-back: start high for 4 consecutive cycles with pairs (1,1), (2,3), (0xFFFF,0xFFFF), (0x80000000,2):
  - done high for 4 consecutive cycles beginning 8 cycles after the first start;
  - products in order: 0x1, 0x6, 0xFFFE0001, 0x100000000.
- Gapped issue: starts in cycles 0, 2, 5 -> dones in cycles 8, 10, 13 only. product holds its value between dones.
- Reset mid-flight: issue 3 ops, assert reset 4 cycles after the first start -> no done for any of them; product=0. A new start right after reset deasserts completes normally 8 cycles later.
- Random regression: 10k random operand pairs with random start density, checked against a 64-bit reference model for value, order and exact latency.
